io_display_scan: RTL
====================

Name: io_display_scan

Overview:
- Downstream consumer of the four memory-mapped output ports IOD, IOE, IOF and IOG that the data memory drives.
- Time-multiplexes the 32 output bits as 8 hexadecimal digits onto a common-anode 7-segment display.
- Takes a tear-free snapshot of all four ports once per scan frame, so CPU writes never show half-updated frames.
- Sits between the processor top level and the board pins.

Parameters:
PRESCALE, 1000, CLK cycles each digit is held; legal range 1..65535; 0 is illegal.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-low reset (0 = reset).
EN_L  input  1  active-low display enable; 1 blanks all anodes, counters keep running.
IOD  input  8  output port D, shown on digits 1 (high nibble) and 0 (low nibble).
IOE  input  8  output port E, shown on digits 3/2.
IOF  input  8  output port F, shown on digits 5/4.
IOG  input  8  output port G, shown on digits 7/6.
AN_L  output  8  active-low digit anodes, one-hot-low; bit i drives digit i.
SEG_L  output  7  active-low segments {g,f,e,d,c,b,a}.
DIG_IDX  output  3  currently selected digit index (debug/verification).
FRAME  output  1  one-cycle pulse marking a new snapshot.

Behaviour:
- Reset (RESET=0, asynchronous, any time including mid-frame):
  - Prescaler=0, DIG_IDX=0, snapshot registers=0x00.
  - AN_L=8'hFF, SEG_L=7'h7F, FRAME=0.
  - Takes effect immediately, without waiting for a CLK edge.
- Prescaler:
  - Counts 0..PRESCALE-1. "tick" is true in the cycle where count==PRESCALE-1; count then wraps to 0.
  - PRESCALE=1 ticks every cycle.
- Digit index: on tick, DIG_IDX increments modulo 8 (7 wraps to 0).
- Snapshot and FRAME:
  - On a tick where DIG_IDX==7, the next edge does three things together: loads the snapshot from IOD/IOE/IOF/IOG, sets DIG_IDX to 0, and sets FRAME to 1.
  - FRAME is 1 for exactly that one following cycle and 0 otherwise.
  - Port changes at any other time are ignored until the next wrap.
  - After reset the snapshot stays 0 until the first wrap, i.e. 8*PRESCALE cycles after RESET is released.
- Nibble select: digit i shows bits [4*(i%2)+3 : 4*(i%2)] of snapshot byte i/2 (byte 0=D, 1=E, 2=F, 3=G).
- Output registers:
  - AN_L and SEG_L are registered and lag DIG_IDX/snapshot by exactly 1 cycle.
  - AN_L = ~(1<<DIG_IDX) when EN_L=0; 8'hFF when EN_L=1.
  - SEG_L is still decoded while EN_L=1.
  - EN_L is sampled synchronously.
- Hex font (SEG_L, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Simultaneous events:
  - A port write in the same cycle as the wrap edge is captured (sampled at that edge).
  - Asserting EN_L during a wrap does not suppress FRAME or the snapshot load.

Optional Feature:
- Macro ZERO_BLANK_EN.
- Defined: for each byte whose high nibble is 0, the odd (high) digit shows blank (SEG_L=7'h7F) instead of "0". Its anode is still driven. The low digit is unaffected, so 0x00 shows as " 0".
- Not defined: all 8 digits always show the hex font, leading zeros included.
- Timing, FRAME and reset behaviour are identical in both builds.

Test Plan:
- Reset check (PRESCALE=4): hold RESET=0, toggle CLK and inputs -> AN_L=FF, SEG_L=7F, FRAME=0, DIG_IDX=0. Pull RESET low mid-frame at DIG_IDX=5 -> all of these return at once, before the next CLK edge.
- Scan timing (PRESCALE=4, EN_L=0): release reset -> DIG_IDX advances every 4 cycles. First FRAME 32 cycles after release, then every 32 cycles. AN_L follows DIG_IDX one cycle later: FE, FD, FB, ..., 7F.
- Font and mapping: IOD=8'h3A, IOE=8'hC5, IOF=8'h90, IOG=8'hEF, wait one frame. Next frame SEG_L per digit 0..7 = 08, 30, 12, 46, 40, 10, 0E, 06.
- Tear-free snapshot: change IOE 8'hC5->8'h11 while DIG_IDX=2 -> digits 2/3 show 12/46 for the rest of that frame, and 79/79 only after the next FRAME pulse.
- Enable and boundary: EN_L=1 for 10 cycles -> AN_L=FF within 1 cycle while FRAME/DIG_IDX timing is unchanged. With PRESCALE=1 -> DIG_IDX changes every cycle and FRAME every 8 cycles.
- ZERO_BLANK_EN build: IOD=8'h00, IOE=8'h0F -> digits 0..3 SEG_L = 40, 7F, 0E, 7F. In the build without the macro -> 40, 40, 0E, 40.

Source files
------------

// File: rtl/io_display_scan.sv
// io_display_scan
//
// Purpose:
//   Shows the four memory-mapped output ports (IOD, IOE, IOF, IOG) as eight
//   hexadecimal digits on a multiplexed common-anode 7-segment display.
//   Each digit is held for PRESCALE clock cycles. All four ports are copied
//   into a snapshot once per scan frame, so a CPU write that lands partway
//   through a frame is never shown half-updated.
//
// Optional build macro:
//   ZERO_BLANK_EN - when defined, the high digit of any byte whose high
//                   nibble is zero is blanked (its anode is still driven).
//
// Ports:
//   CLK      in   1  system clock, rising edge
//   RESET    in   1  asynchronous active-low reset
//   EN_L     in   1  active-low display enable (1 blanks all anodes)
//   IOD      in   8  port D -> digits 1/0
//   IOE      in   8  port E -> digits 3/2
//   IOF      in   8  port F -> digits 5/4
//   IOG      in   8  port G -> digits 7/6
//   AN_L     out  8  active-low one-hot digit anodes
//   SEG_L    out  7  active-low segments {g,f,e,d,c,b,a}
//   DIG_IDX  out  3  currently selected digit index
//   FRAME    out  1  one-cycle pulse when a new snapshot is loaded

module io_display_scan #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN_L,
  input  logic [7:0] IOD,
  input  logic [7:0] IOE,
  input  logic [7:0] IOF,
  input  logic [7:0] IOG,
  output logic [7:0] AN_L,
  output logic [6:0] SEG_L,
  output logic [2:0] DIG_IDX,
  output logic       FRAME
);

  localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);

  logic [15:0] count;
  logic        tick;
  logic [7:0]  snap_d;
  logic [7:0]  snap_e;
  logic [7:0]  snap_f;
  logic [7:0]  snap_g;
  logic [7:0]  byte_sel;
  logic [3:0]  nibble;
  logic [6:0]  seg_next;
  logic [7:0]  an_next;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign tick = (count == LAST_COUNT);

  // Digit i shows nibble (i%2) of snapshot byte i/2.
  always_comb begin
    byte_sel = 8'h00;
    case (DIG_IDX[2:1])
      2'd0: byte_sel = snap_d;
      2'd1: byte_sel = snap_e;
      2'd2: byte_sel = snap_f;
      default: byte_sel = snap_g;
    endcase
    nibble   = DIG_IDX[0] ? byte_sel[7:4] : byte_sel[3:0];
    seg_next = hex_font(nibble);
`ifdef ZERO_BLANK_EN
    if (DIG_IDX[0] && (nibble == 4'h0)) begin
      seg_next = 7'h7F;
    end
`else
`endif
    an_next = EN_L ? 8'hFF : ~(8'b0000_0001 << DIG_IDX);
  end

  // Prescaler, digit index and frame snapshot. The snapshot, the index wrap
  // and the FRAME pulse all happen on the same edge that ends digit 7.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count   <= 16'd0;
      DIG_IDX <= 3'd0;
      FRAME   <= 1'b0;
      snap_d  <= 8'h00;
      snap_e  <= 8'h00;
      snap_f  <= 8'h00;
      snap_g  <= 8'h00;
    end else begin
      FRAME <= 1'b0;
      if (tick) begin
        count <= 16'd0;
        if (DIG_IDX == 3'd7) begin
          DIG_IDX <= 3'd0;
          FRAME   <= 1'b1;
          snap_d  <= IOD;
          snap_e  <= IOE;
          snap_f  <= IOF;
          snap_g  <= IOG;
        end else begin
          DIG_IDX <= DIG_IDX + 3'd1;
        end
      end else begin
        count <= count + 16'd1;
      end
    end
  end

  // Pin drivers are registered, so they trail DIG_IDX/snapshot by one cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      AN_L  <= 8'hFF;
      SEG_L <= 7'h7F;
    end else begin
      AN_L  <= an_next;
      SEG_L <= seg_next;
    end
  end

endmodule
